// File: rtl/manta_resp_tx.sv
// Response serializer: frames each read response as "D" + 4 hex digits + CR LF for the UART.
// Optional MANTA_RESP_WRITE_ACK_EN also frames write responses as "W" CR LF.
module manta_resp_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        busy_o,
    output logic        overrun_o
);

`ifdef MANTA_RESP_WRITE_ACK_EN
    localparam logic WackEn = 1'b1;
`else
    localparam logic WackEn = 1'b0;
`endif

    typedef enum logic {StIdle, StSend} state_t;

    state_t      r_state, w_state_d;
    logic [15:0] r_act_data, w_act_data_d;
    logic        r_act_w, w_act_w_d;
    logic [2:0]  r_idx, w_idx_d;
    logic [15:0] r_pend_data, w_pend_data_d;
    logic        r_pend_w, w_pend_w_d;
    logic        r_pend_v, w_pend_v_d;
    logic        r_overrun, w_overrun_d;
    logic [7:0]  r_tx_data, w_tx_data_d;
    logic        r_tx_valid, w_tx_valid_d;

    logic w_acc, w_xfer, w_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] frame_byte(input logic [15:0] d, input logic w,
                                              input logic [2:0] idx);
        logic [7:0] b;
        if (w) begin
            case (idx)
                3'd0:    b = 8'h57;
                3'd1:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end else begin
            case (idx)
                3'd0:    b = 8'h44;
                3'd1:    b = hex_char(d[15:12]);
                3'd2:    b = hex_char(d[11:8]);
                3'd3:    b = hex_char(d[7:4]);
                3'd4:    b = hex_char(d[3:0]);
                3'd5:    b = 8'h0D;
                default: b = 8'h0A;
            endcase
        end
        return b;
    endfunction

    always_comb begin
        w_acc  = valid_i & (~rw_i | WackEn);
        w_xfer = r_tx_valid & tx_ready_i;
        w_last = w_xfer & (r_idx == (r_act_w ? 3'd2 : 3'd6));

        w_state_d     = r_state;
        w_act_data_d  = r_act_data;
        w_act_w_d     = r_act_w;
        w_idx_d       = r_idx;
        w_pend_data_d = r_pend_data;
        w_pend_w_d    = r_pend_w;
        w_pend_v_d    = r_pend_v;
        w_overrun_d   = r_overrun;

        case (r_state)
            StIdle: begin
                if (w_acc) begin
                    w_act_data_d = data_i;
                    w_act_w_d    = rw_i & WackEn;
                    w_idx_d      = 3'd0;
                    w_state_d    = StSend;
                end
            end
            default: begin
                if (w_last) begin
                    if (r_pend_v) begin
                        // Pending drains into active; a same-cycle arrival refills pending.
                        w_act_data_d = r_pend_data;
                        w_act_w_d    = r_pend_w;
                        w_idx_d      = 3'd0;
                        w_pend_v_d   = w_acc;
                        if (w_acc) begin
                            w_pend_data_d = data_i;
                            w_pend_w_d    = rw_i & WackEn;
                        end
                    end else if (w_acc) begin
                        w_act_data_d = data_i;
                        w_act_w_d    = rw_i & WackEn;
                        w_idx_d      = 3'd0;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    if (w_xfer) begin
                        w_idx_d = r_idx + 3'd1;
                    end
                    if (w_acc) begin
                        if (!r_pend_v) begin
                            w_pend_data_d = data_i;
                            w_pend_w_d    = rw_i & WackEn;
                            w_pend_v_d    = 1'b1;
                        end else begin
                            w_overrun_d = 1'b1;
                        end
                    end
                end
            end
        endcase

        // Outputs are registered from the next-state view so byte 0 appears one cycle after valid_i.
        w_tx_valid_d = (w_state_d == StSend);
        w_tx_data_d  = w_tx_valid_d ? frame_byte(w_act_data_d, w_act_w_d, w_idx_d) : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_act_data  <= 16'h0000;
            r_act_w     <= 1'b0;
            r_idx       <= 3'd0;
            r_pend_data <= 16'h0000;
            r_pend_w    <= 1'b0;
            r_pend_v    <= 1'b0;
            r_overrun   <= 1'b0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_act_data  <= w_act_data_d;
            r_act_w     <= w_act_w_d;
            r_idx       <= w_idx_d;
            r_pend_data <= w_pend_data_d;
            r_pend_w    <= w_pend_w_d;
            r_pend_v    <= w_pend_v_d;
            r_overrun   <= w_overrun_d;
            r_tx_data   <= w_tx_data_d;
            r_tx_valid  <= w_tx_valid_d;
        end
    end

    assign tx_data_o  = r_tx_data;
    assign tx_valid_o = r_tx_valid;
    assign busy_o     = (r_state == StSend);
    assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_manta_resp_tx.sv
// Bench for manta_resp_tx: table vectors, directed corner sequences and random traffic vs a
// byte-queue reference model.
module tb_manta_resp_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i;
    logic        rw_i;
    logic        valid_i;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        overrun_o;

    int n_checks = 0;
    int n_fail = 0;

`ifdef MANTA_RESP_WRITE_ACK_EN
    localparam logic WackEn = 1'b1;
`else
    localparam logic WackEn = 1'b0;
`endif

    always #5 clk = ~clk;

    manta_resp_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_i     (data_i),
        .rw_i       (rw_i),
        .valid_i    (valid_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o)
    );

    // Reference model: bytes still owed for the current frame, plus one pending response.
    logic [7:0]  m_bytes[$];
    logic        m_pend_v;
    logic [15:0] m_pend_d;
    logic        m_pend_w;
    logic        m_ovr;
    logic [7:0]  sent[$];
    logic [7:0]  exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'd48 + {4'h0, n}) : (8'd55 + {4'h0, n});
    endfunction

    function automatic int frame_len(input logic w);
        return w ? 3 : 7;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [15:0] d, input logic w, input int i);
        logic [15:0] sh;
        if (w) return (i == 0) ? 8'h57 : ((i == 1) ? 8'h0D : 8'h0A);
        if (i == 0) return 8'h44;
        if (i == 5) return 8'h0D;
        if (i == 6) return 8'h0A;
        sh = d >> (16 - 4 * i);
        return hexc(sh[3:0]);
    endfunction

    task automatic load_frame(input logic [15:0] d, input logic w);
        for (int i = 0; i < frame_len(w); i++) m_bytes.push_back(frame_byte(d, w, i));
    endtask

    task automatic add_exp(input logic [15:0] d, input logic w);
        for (int i = 0; i < frame_len(w); i++) exp_q.push_back(frame_byte(d, w, i));
    endtask

    task automatic model_clear();
        m_bytes.delete();
        m_pend_v = 1'b0;
        m_pend_d = 16'h0;
        m_pend_w = 1'b0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic rw, input logic [15:0] d,
                              input logic rdy);
        logic busy, acc, fin;
        busy = (m_bytes.size() > 0);
        acc  = v && (!rw || WackEn);
        fin  = 1'b0;
        if (busy && rdy) begin
            void'(m_bytes.pop_front());
            fin = (m_bytes.size() == 0);
        end
        if (fin) begin
            if (m_pend_v) begin
                load_frame(m_pend_d, m_pend_w);
                m_pend_v = acc;
                if (acc) begin
                    m_pend_d = d;
                    m_pend_w = rw;
                end
            end else if (acc) begin
                load_frame(d, rw);
            end
        end else if (acc) begin
            if (!busy) load_frame(d, rw);
            else if (!m_pend_v) begin
                m_pend_d = d;
                m_pend_w = rw;
                m_pend_v = 1'b1;
            end else m_ovr = 1'b1;
        end
    endtask

    task automatic check_outputs();
        chk("tx_valid", 32'(tx_valid_o), 32'(m_bytes.size() > 0));
        if (m_bytes.size() > 0) chk("tx_data", 32'(tx_data_o), 32'(m_bytes[0]));
        chk("busy", 32'(busy_o), 32'(m_bytes.size() > 0));
        chk("overrun", 32'(overrun_o), 32'(m_ovr));
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at the next negedge.
    task automatic step(input logic v, input logic rw, input logic [15:0] d, input logic rdy);
        valid_i    = v;
        rw_i       = rw;
        data_i     = d;
        tx_ready_i = rdy;
        if (tx_valid_o && rdy) sent.push_back(tx_data_o);
        @(posedge clk);
        model_step(v, rw, d, rdy);
        @(negedge clk);
        valid_i = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        valid_i    = 1'b0;
        tx_ready_i = 1'b0;
        rst_n      = 1'b0;
        #1;
        model_clear();
        sent.delete();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic compare_sent(input string name);
        int n;
        chk({name, "_len"}, 32'(sent.size()), 32'(exp_q.size()));
        n = (sent.size() < exp_q.size()) ? sent.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({name, "_byte"}, 32'(sent[i]), 32'(exp_q[i]));
    endtask

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        eb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       rdy;

        tbl[0] = '{1'b1, 16'hBEEF, 1'b1, 1'b1, 8'h44, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h42, 1'b1};
        tbl[2] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h45, 1'b1};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h45, 1'b1};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h46, 1'b1};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h0D, 1'b1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 8'h0A, 1'b1};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0};

        valid_i    = 1'b0;
        rw_i       = 1'b0;
        data_i     = 16'h0;
        tx_ready_i = 1'b0;
        model_clear();
        #12;
        chk("rst_tx_data", 32'(tx_data_o), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_overrun", 32'(overrun_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single read 0xBEEF with ready held high.
        for (int i = 0; i < 8; i++) begin
            valid_i    = tbl[i].v;
            rw_i       = 1'b0;
            data_i     = tbl[i].d;
            tx_ready_i = tbl[i].rdy;
            @(posedge clk);
            @(negedge clk);
            valid_i = 1'b0;
            chk("tbl_valid", 32'(tx_valid_o), 32'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_data", 32'(tx_data_o), 32'(tbl[i].ed));
            chk("tbl_busy", 32'(busy_o), 32'(tbl[i].eb));
        end

        // Backpressure: data held stable through stalls.
        do_reset();
        step(1'b1, 1'b0, 16'h0A5F, 1'b1);
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        for (int k = 0; k < 40 && sent.size() < 7; k++) begin
            rdy = (k % 3 == 0);
            if (prev_stall) chk("stall_stable", 32'(tx_data_o), 32'(prev_data));
            prev_stall = tx_valid_o && !rdy;
            prev_data  = tx_data_o;
            step(1'b0, 1'b0, 16'h0, rdy);
        end
        add_exp(16'h0A5F, 1'b0);
        compare_sent("backpressure");

        // Pending then overrun.
        do_reset();
        step(1'b1, 1'b0, 16'h1234, 1'b1);
        step(1'b1, 1'b0, 16'h5678, 1'b1);
        step(1'b1, 1'b0, 16'h9ABC, 1'b1);
        repeat (16) step(1'b0, 1'b0, 16'h0, 1'b1);
        add_exp(16'h1234, 1'b0);
        add_exp(16'h5678, 1'b0);
        compare_sent("pend_ovr");
        chk("ovr_sticky", 32'(overrun_o), 32'h1);

        // New read arriving exactly on the final-byte accept while pending is full.
        do_reset();
        step(1'b1, 1'b0, 16'h0F0F, 1'b1);
        step(1'b1, 1'b0, 16'h1111, 1'b1);
        repeat (5) step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h2222, 1'b1);
        repeat (16) step(1'b0, 1'b0, 16'h0, 1'b1);
        add_exp(16'h0F0F, 1'b0);
        add_exp(16'h1111, 1'b0);
        add_exp(16'h2222, 1'b0);
        compare_sent("final_accept");
        chk("final_no_ovr", 32'(overrun_o), 32'h0);

        // Write response.
        do_reset();
        step(1'b1, 1'b1, 16'h1234, 1'b1);
        repeat (6) step(1'b0, 1'b0, 16'h0, 1'b1);
        if (WackEn) add_exp(16'h0, 1'b1);
        compare_sent("write");

        // Async reset mid-frame, with overrun set beforehand.
        do_reset();
        step(1'b1, 1'b0, 16'h0001, 1'b1);
        step(1'b1, 1'b0, 16'h0002, 1'b1);
        step(1'b1, 1'b0, 16'h0003, 1'b1);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx_data", 32'(tx_data_o), 32'h00);
        chk("arst_tx_valid", 32'(tx_valid_o), 32'h0);
        chk("arst_busy", 32'(busy_o), 32'h0);
        chk("arst_overrun", 32'(overrun_o), 32'h0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'hC0DE, 1'b1);
        chk("restart_byte0", 32'(tx_data_o), 32'h44);
        repeat (8) step(1'b0, 1'b0, 16'h0, 1'b1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 16'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        repeat (30) step(1'b0, 1'b0, 16'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
